// File: rtl/frame_read_arbiter.sv
// Two-requester arbiter for the frame buffer read port (display = 0, colour detect = 1).
// Optional macro DISPLAY_PREEMPT_EN: display preempts colour-detect bursts.
module frame_read_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int RD_LATENCY = 2,
  parameter int BURST_LEN  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] rddata,
  output logic              busy
);

`ifdef DISPLAY_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                  state;
  logic [7:0]              cnt;
  logic                    last_owner;
  logic [ADDR_W-1:0]       addr_q;
  logic [RD_LATENCY-1:0]   pipe_valid;
  logic [RD_LATENCY-1:0]   pipe_owner;
  logic                    beat0, beat1;
  logic                    burst_done;

  assign gnt0       = (state == OWN0);
  assign gnt1       = (state == OWN1);
  assign beat0      = req0 && gnt0;
  assign beat1      = req1 && gnt1;
  assign burst_done = (cnt == BURST_LAST);

  assign rdaddress = beat0 ? addr0 : (beat1 ? addr1 : addr_q);

  // Data is shared; only the tag at the end of the pipe decides who sees it.
  assign rdata0  = rddata;
  assign rdata1  = rddata;
  assign rvalid0 = pipe_valid[RD_LATENCY-1] && !pipe_owner[RD_LATENCY-1];
  assign rvalid1 = pipe_valid[RD_LATENCY-1] &&  pipe_owner[RD_LATENCY-1];
  assign busy    = |pipe_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      last_owner <= 1'b1;
      addr_q     <= '0;
      pipe_valid <= '0;
      pipe_owner <= '0;
    end else begin
      pipe_valid[0] <= beat0 || beat1;
      pipe_owner[0] <= beat1;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_owner[k] <= pipe_owner[k-1];
      end
      if (beat0 || beat1) addr_q <= rdaddress;

      case (state)
        IDLE: begin
          if (req0 && req1)  state <= (last_owner || PREEMPT) ? OWN0 : OWN1;
          else if (req0)     state <= OWN0;
          else if (req1)     state <= OWN1;
        end
        OWN0: begin
          if (!req0) begin
            state      <= req1 ? OWN1 : IDLE;
            cnt        <= 8'd0;
            last_owner <= 1'b0;
          end else if (burst_done) begin
            cnt <= 8'd0;
            if (req1 && !PREEMPT) begin
              state      <= OWN1;
              last_owner <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        OWN1: begin
          if (!req1) begin
            state      <= req0 ? OWN0 : IDLE;
            cnt        <= 8'd0;
            last_owner <= 1'b1;
          end else if (burst_done) begin
            cnt <= 8'd0;
            if (req0) begin
              state      <= OWN0;
              last_owner <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
          // Display request overrides whatever the burst logic decided.
          if (PREEMPT && req0) begin
            state      <= OWN0;
            cnt        <= 8'd0;
            last_owner <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
